// File: rtl/graph_call_unit.sv
// Call initiator for a compiled dataflow graph: launches one call, collects the end token
// (or times out), returns it downstream, then holds the graph in reset before the next call.
`timescale 1ns/1ps
module graph_call_unit #(
   parameter int DW         = 32,
   parameter int TIMEOUT    = 1024,
   parameter int CLR_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   input  logic [DW-1:0] req_c,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          g_rst,
   output logic          g_start_in,
   output logic          g_start_valid,
   input  logic          g_start_ready,
   output logic [DW-1:0] g_a_din,
   output logic [DW-1:0] g_b_din,
   output logic [DW-1:0] g_c_din,
   input  logic [DW-1:0] g_end_out,
   input  logic          g_end_valid,
   output logic          g_end_ready
);
   localparam int WDW = $clog2(TIMEOUT);
   localparam int CW  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  CLR_LAST = CW'(CLR_CYCLES - 1);

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   state_t         r_state;
   logic [CW-1:0]  r_clr_cnt;
   logic [WDW-1:0] r_wd;
   logic           r_req_ready, r_rsp_valid, r_rsp_err, r_g_rst, r_start, r_end_ready;
   logic [DW-1:0]  r_rsp_data, r_a, r_b, r_c;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_CLEAR;
         r_clr_cnt   <= '0;
         r_wd        <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
         r_g_rst     <= 1'b1;
         r_start     <= 1'b0;
         r_end_ready <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               if (r_clr_cnt == CLR_LAST) begin
                  r_clr_cnt   <= '0;
                  r_g_rst     <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               if (req_valid) begin
                  r_a         <= req_a;
                  r_b         <= req_b;
                  r_c         <= req_c;
                  r_wd        <= '0;
                  r_req_ready <= 1'b0;
                  r_start     <= 1'b1;
                  r_state     <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (g_start_ready) begin
                  r_start     <= 1'b0;
                  r_end_ready <= 1'b1;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A token on the final watchdog cycle still wins over the timeout.
               if (g_end_valid) begin
                  r_rsp_data  <= g_end_out;
                  r_rsp_err   <= 1'b0;
                  r_end_ready <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (r_wd == WD_LAST) begin
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_end_ready <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b0;
                  r_a         <= '0;
                  r_b         <= '0;
                  r_c         <= '0;
                  r_g_rst     <= 1'b1;
                  r_clr_cnt   <= '0;
                  r_state     <= S_CLEAR;
               end
            end
            default: begin
               r_g_rst   <= 1'b1;
               r_clr_cnt <= '0;
               r_state   <= S_CLEAR;
            end
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign rsp_err       = r_rsp_err;
   assign g_rst         = r_g_rst;
   assign g_start_in    = r_start;
   assign g_start_valid = r_start;
   assign g_a_din       = r_a;
   assign g_b_din       = r_b;
   assign g_c_din       = r_c;
   assign g_end_ready   = r_end_ready;
endmodule

// File: tb/tb_graph_call_unit.sv
// Bench for graph_call_unit: a behavioural 2-cycle multiplier graph plus a queue of
// expected a*b*c results computed at request time.
`timescale 1ns/1ps
module tb_graph_call_unit;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int CLR = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [DW-1:0] req_a = '0, req_b = '0, req_c = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          g_rst, g_start_in, g_start_valid;
   logic          g_start_ready;
   logic [DW-1:0] g_a_din, g_b_din, g_c_din;
   logic [DW-1:0] g_end_out;
   logic          g_end_valid, g_end_ready;

   logic          sr_en = 1'b1;
   logic          hang = 1'b0;
   logic          inj_ev = 1'b0;
   logic          m_busy = 1'b0, m_ev = 1'b0;
   int            m_cnt = 0;
   logic [DW-1:0] m_res = '0;

   int n_pass = 0;
   int n_total = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   graph_call_unit #(.DW(DW), .TIMEOUT(TO), .CLR_CYCLES(CLR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .g_rst(g_rst), .g_start_in(g_start_in), .g_start_valid(g_start_valid),
      .g_start_ready(g_start_ready),
      .g_a_din(g_a_din), .g_b_din(g_b_din), .g_c_din(g_c_din),
      .g_end_out(g_end_out), .g_end_valid(g_end_valid), .g_end_ready(g_end_ready)
   );

   assign g_start_ready = sr_en;
   assign g_end_valid   = m_ev | inj_ev;
   assign g_end_out     = inj_ev ? 32'hDEAD_BEEF : m_res;

   // Behavioural graph: product ready two cycles after the start token, held until taken.
   always @(posedge clk) begin
      if (g_rst) begin
         m_busy <= 1'b0;
         m_ev   <= 1'b0;
         m_cnt  <= 0;
      end else if (g_start_valid && g_start_ready && !m_busy) begin
         m_busy <= 1'b1;
         m_cnt  <= 2;
         m_res  <= g_a_din * g_b_din * g_c_din;
      end else if (m_busy) begin
         if (m_ev && g_end_ready) begin
            m_ev   <= 1'b0;
            m_busy <= 1'b0;
         end else if (m_cnt == 1) begin
            m_cnt <= 0;
            if (!hang) m_ev <= 1'b1;
         end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic send_req(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
      int n;
      req_a = a; req_b = b; req_c = c;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_val("req_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      req_a = '0; req_b = '0; req_c = '0;
   endtask

   task automatic wait_rsp(output logic [DW-1:0] d, output logic e);
      int n;
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("rsp_valid", rsp_valid, 1);
      d = rsp_data;
      e = rsp_err;
      if (rsp_ready) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      check_val("idle_ready", req_ready, 1);
   endtask

   initial begin
      logic [DW-1:0] a, b, c, d, e_exp;
      logic          e;
      int            n;
      logic          saw;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_g_rst", g_rst, 1);
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_outs", {rsp_valid, rsp_err, g_start_valid, g_start_in, g_end_ready}, 0);
      check_val("rst_data", {rsp_data, g_a_din}, 0);
      rst = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 20);
      check_val("clr_after_reset", n, CLR);
      check_val("g_rst_released", g_rst, 0);
      $display("reset release: req_ready after %0d cycles", n);

      // Single call 3*5*7
      send_req(3, 5, 7);
      check_val("launch_valid", {g_start_valid, g_start_in}, 2'b11);
      check_val("launch_args", {g_a_din, g_b_din, g_c_din}, {32'd3, 32'd5, 32'd7});
      wait_rsp(d, e);
      check_val("single_data", d, 105);
      check_val("single_err", e, 0);
      $display("call a=3 b=5 c=7 -> data=%0d err=%0d", d, e);
      check_val("post_g_rst0", g_rst, 1);
      @(negedge clk);
      check_val("post_g_rst1", g_rst, 1);
      check_val("post_ready_low", req_ready, 0);
      @(negedge clk);
      check_val("post_g_rst2", g_rst, 0);
      check_val("post_ready", req_ready, 1);

      // 100 back-to-back calls against the queue model
      for (int i = 0; i < 100; i++) begin
         if (i == 0) begin a = 32'hFFFF_FFFF; b = 2; c = 1; end
         else begin a = $urandom; b = $urandom; c = (i % 4 == 0) ? $urandom_range(0, 3) : $urandom; end
         e_exp = a * b * c;
         exp_q.push_back(e_exp);
         send_req(a, b, c);
         wait_rsp(d, e);
         e_exp = exp_q.pop_front();
         check_val("rand_data", d, e_exp);
         check_val("rand_err", e, 0);
         $display("call %0d a=%08h b=%08h c=%08h -> data=%08h exp=%08h err=%0d", i, a, b, c, d, e_exp, e);
      end

      // Start backpressure
      wait_idle();
      sr_en = 1'b0;
      send_req(32'h11, 32'h22, 32'h33);
      for (int i = 0; i < 5; i++) begin
         check_val("bp_start", {g_start_valid, g_start_in, g_end_ready}, 3'b110);
         check_val("bp_args", {g_a_din, g_b_din, g_c_din}, {32'h11, 32'h22, 32'h33});
         @(negedge clk);
      end
      sr_en = 1'b1;
      @(negedge clk);
      check_val("bp_wait_entered", {g_end_ready, g_start_valid}, 2'b10);
      wait_rsp(d, e);
      check_val("bp_data", d, 32'h11 * 32'h22 * 32'h33);
      check_val("bp_err", e, 0);
      $display("backpressured call -> data=%08h err=%0d", d, e);

      // Watchdog timeout
      wait_idle();
      hang = 1'b1;
      send_req(1, 2, 3);
      n = 0;
      for (int i = 0; i < 100 && !rsp_valid; i++) begin
         @(negedge clk);
         if (g_end_ready) n++;
      end
      check_val("to_wait_cycles", n, TO);
      check_val("to_rsp", {rsp_valid, rsp_err}, 2'b11);
      check_val("to_data", rsp_data, 0);
      $display("timeout call -> wait cycles=%0d err=%0d data=%0h", n, rsp_err, rsp_data);
      @(negedge clk);
      hang = 1'b0;

      // Response backpressure with a stray end pulse
      wait_idle();
      rsp_ready = 1'b0;
      send_req(9, 10, 11);
      wait_rsp(d, e);
      for (int i = 0; i < 10; i++) begin
         inj_ev = (i == 3);
         check_val("rb_hold", {rsp_valid, rsp_err, req_ready, g_end_ready}, 4'b1000);
         check_val("rb_data", rsp_data, 990);
         @(negedge clk);
      end
      inj_ev = 1'b0;
      check_val("rb_data_after_pulse", rsp_data, 990);
      rsp_ready = 1'b1;
      @(negedge clk);
      check_val("rb_done", {rsp_valid, g_rst}, 2'b01);
      $display("response backpressure call -> data=%0d", d);

      // Reset while in WAIT
      wait_idle();
      hang = 1'b1;
      send_req(4, 5, 6);
      n = 0;
      while (!g_end_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("mid_in_wait", g_end_ready, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("mid_g_rst", g_rst, 1);
      check_val("mid_outs", {req_ready, rsp_valid, rsp_err, g_start_valid, g_end_ready}, 0);
      check_val("mid_args", {g_a_din, rsp_data}, 0);
      rst = 1'b1;
      hang = 1'b0;
      n = 0;
      saw = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (rsp_valid) saw = 1'b1;
      end while (!req_ready && n < 20);
      check_val("mid_clr_cycles", n, CLR);
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid) saw = 1'b1;
      end
      check_val("mid_no_stale_rsp", saw, 0);
      $display("mid-call reset: req_ready after %0d cycles, stale response=%0d", n, saw);

      // Normal call after the abort
      send_req(32'h1234, 32'h10, 32'h2);
      wait_rsp(d, e);
      check_val("after_abort_data", d, 32'h1234 * 32'h10 * 32'h2);
      check_val("after_abort_err", e, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end
endmodule

// File: doc/graph_call_unit.md
# graph_call_unit

Synthesizable initiator for a compiled dataflow graph such as `mul_graph`; it is the hardware counterpart of the graph's start/end token interface. It accepts one call request (three operands) on an upstream valid/ready port and drives the graph's argument and start ports. It then collects the single end token and returns it on a downstream valid/ready port. Between calls it holds the graph in reset so every call starts from a clean graph state; a watchdog converts a hung graph into an error response.

## Interface
- `DW`, 32, operand and result width.
- `TIMEOUT`, 1024, maximum WAIT cycles before error response (≥2).
- `CLR_CYCLES`, 2, cycles graph reset is held after every call and after own reset (≥1).

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  call request valid.
- `req_ready`  out  1  call request ready.
- `req_a`, `req_b`, `req_c`  in  DW  operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response ready.
- `rsp_data`  out  DW  graph result; 0 on error.
- `rsp_err`  out  1  1 = timeout, no end token received.
- `g_rst`  out  1  graph reset, active-high.
- `g_start_in`, `g_start_valid`  out  1  start token and valid.
- `g_start_ready`  in  1  graph start ready.
- `g_a_din`, `g_b_din`, `g_c_din`  out  DW  graph arguments.
- `g_end_out`  in  DW  graph result.
- `g_end_valid`  in  1  graph end valid.
- `g_end_ready`  out  1  graph end ready.

## Operation
- FSM states: CLEAR, IDLE, LAUNCH, WAIT, RESP. All outputs are registered.
- Reset (`rst`=0 at an edge):
  - State goes to CLEAR and the clear counter goes to 0.
  - `g_rst`=1; all other outputs 0, including args, `rsp_data` and `rsp_err`.
- CLEAR:
  - `g_rst`=1 and args are 0.
  - After CLR_CYCLES cycles in CLEAR, go to IDLE and deassert `g_rst`.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`: capture the operands into the arg registers, clear the watchdog, go to LAUNCH.
- LAUNCH:
  - `g_start_in`=`g_start_valid`=1 and args are driven.
  - Hold until `g_start_ready` is sampled 1 with start valid, then go to WAIT with start deasserted.
- WAIT:
  - `g_end_ready`=1 and args remain driven.
  - On `g_end_valid`: capture `g_end_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT: `rsp_data`=0, `rsp_err`=1, go to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_data`/`rsp_err` are stable.
  - On `rsp_ready`, go to CLEAR.
- `req_ready` is 0 in every state except IDLE. Exactly one call is outstanding at a time.
- An end token arriving outside WAIT is ignored (`g_end_ready`=0).
- `g_end_valid` and the timeout on the same cycle: the token wins and `rsp_err`=0.
- The result is passed through unmodified at DW bits; the block performs no arithmetic.

## Timing
- The request handshake at edge N gives `g_start_valid`=1 from N+1.
- A start handshake at edge M gives WAIT from M+1; `g_end_ready`=1 from M+1.
- End token sampled at edge K gives `rsp_valid`=1 from K+1.
- Response handshake at edge R:
  - `g_rst`=1 from R+1 for CLR_CYCLES cycles.
  - `req_ready`=1 at R+1+CLR_CYCLES.
- Minimum call turnaround with an immediately ready graph and consumer: 4+CLR_CYCLES+graph latency cycles.
- After reset release, `req_ready` first rises CLR_CYCLES cycles later.
- Reset mid-call (any state) aborts the call with no response, and the graph is reset via CLEAR.
- The watchdog counts only cycles spent in WAIT; backpressure in LAUNCH and RESP has no timeout.

## Test plan
- Single call with a behavioral 2-cycle multiplier graph, a=3, b=5, c=7 → one response: `rsp_data`=105 (0x69), `rsp_err`=0; `g_rst` high 2 cycles afterwards.
- 100 back-to-back random calls against the model, computing a·b·c mod 2^32 (e.g. 0xFFFFFFFF·2·1 → 0xFFFFFFFE) → every response matches and calls stay in order.
- `g_start_ready` held 0 for 5 cycles → `g_start_valid`, args and `g_start_in` stay stable; WAIT is entered the cycle after ready rises; no timeout occurs.
- Graph never asserts end, TIMEOUT=16 → `rsp_valid` rises after 16 WAIT cycles with `rsp_err`=1 and `rsp_data`=0.
- `rsp_ready` held 0 for 10 cycles → response stable, `req_ready`=0 throughout, and an extra `g_end_valid` pulse is ignored.
- `rst`=0 for one cycle while in WAIT → next cycle `g_rst`=1 and all other outputs 0; `req_ready` returns after CLR_CYCLES; no stale response appears.
